// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Brief    : First-word-fall-through byte FIFO behind a UART receiver, with
//             a sticky overflow flag and a count of buffered line terminators.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int          DEPTH = 16,
    parameter int          AW    = 4,
    parameter logic [7:0]  TERM  = 8'h0A
) (
    input  logic          clk,
    input  logic          rstn,          // active-high synchronous reset
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    input  logic          overflow_clr,
    output logic [AW:0]   line_cnt,
    output logic          line_avail
);

    localparam logic [AW:0]   c_depth = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] c_one   = AW'(1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [AW:0]   r_line_cnt;
    logic          r_overflow;
    logic          r_out_valid;
    logic [7:0]    r_out_data;

    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [AW-1:0] w_rd_next;
    logic [AW:0]   w_count_next;
    logic [AW:0]   w_line_next;
    logic [7:0]    w_head_next;

    // Handshake decode, next head pointer and the byte that will be at the head
    always_comb begin
        w_pop       = r_out_valid & out_ready;
        w_push      = in_valid & ((r_count != c_depth) | w_pop);
        w_drop      = in_valid & (r_count == c_depth) & ~w_pop;
        w_rd_next   = w_pop ? (r_rd_ptr + c_one) : r_rd_ptr;
        // A byte being written into the slot that becomes the head must be
        // forwarded, since the array still holds the old contents this cycle.
        w_head_next = (w_push && (r_wr_ptr == w_rd_next)) ? in_data : r_mem[w_rd_next];

        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end

        w_line_next = r_line_cnt;
        if ((w_push && in_data == TERM) && !(w_pop && r_out_data == TERM)) begin
            w_line_next = r_line_cnt + 1'b1;
        end else if (!(w_push && in_data == TERM) && (w_pop && r_out_data == TERM)) begin
            w_line_next = r_line_cnt - 1'b1;
        end
    end

    // Byte storage; contents need no reset
    always_ff @(posedge clk) begin
        if (w_push && !rstn) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointers, occupancy, terminator count, overflow and registered head
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_line_cnt  <= '0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_one;
            end
            r_rd_ptr    <= w_rd_next;
            r_count     <= w_count_next;
            r_line_cnt  <= w_line_next;
            r_out_valid <= (w_count_next != '0);
            r_out_data  <= w_head_next;
            // A drop in the same cycle as a clear leaves the flag set
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (overflow_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign count      = r_count;
    assign full       = (r_count == c_depth);
    assign empty      = (r_count == '0);
    assign overflow   = r_overflow;
    assign line_cnt   = r_line_cnt;
    assign line_avail = (r_line_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_fifo
//  Brief    : Directed self-checking bench for uart_rx_fifo.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       overflow_clr = 1'b0;
    logic [4:0] line_cnt;
    logic       line_avail;

    int n_pass  = 0;
    int n_total = 0;

    uart_rx_fifo #(.DEPTH(16), .AW(4), .TERM(8'h0A)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .line_cnt     (line_cnt),
        .line_avail   (line_avail)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_byte();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        tick();
        tick();
        rstn = 1'b0;
        n_total++; if (count !== 5'd0) $display("FAIL reset_count got %0d expected 0", count); else n_pass++;
        n_total++; if (empty !== 1'b1) $display("FAIL reset_empty got %b expected 1", empty); else n_pass++;
        n_total++; if (full !== 1'b0) $display("FAIL reset_full got %b expected 0", full); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b expected 0", out_valid); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b expected 0", overflow); else n_pass++;
        n_total++; if (line_cnt !== 5'd0 || line_avail !== 1'b0)
            $display("FAIL reset_line got %0d/%b expected 0/0", line_cnt, line_avail); else n_pass++;
        n_total++; if (out_data !== 8'h00) $display("FAIL reset_out_data got %h expected 00", out_data); else n_pass++;
    endtask

    task automatic test_single();
        push_byte(8'h41);
        n_total++; if (out_valid !== 1'b1 || out_data !== 8'h41)
            $display("FAIL single_head got %b/%h expected 1/41", out_valid, out_data); else n_pass++;
        n_total++; if (count !== 5'd1 || empty !== 1'b0)
            $display("FAIL single_count got %0d/%b expected 1/0", count, empty); else n_pass++;
        pop_byte();
        n_total++; if (count !== 5'd0 || empty !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL single_pop got %0d/%b/%b expected 0/1/0", count, empty, out_valid); else n_pass++;
        // out_ready on an empty FIFO must not underflow
        pop_byte();
        n_total++; if (count !== 5'd0 || out_valid !== 1'b0)
            $display("FAIL empty_pop got %0d/%b expected 0/0", count, out_valid); else n_pass++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        n_total++; if (full !== 1'b1 || count !== 5'd16)
            $display("FAIL fill got %b/%0d expected 1/16", full, count); else n_pass++;
        n_total++; if (line_cnt !== 5'd1) $display("FAIL fill_line got %0d expected 1", line_cnt); else n_pass++;
        push_byte(8'hAA);
        n_total++; if (overflow !== 1'b1 || count !== 5'd16)
            $display("FAIL drop got %b/%0d expected 1/16", overflow, count); else n_pass++;
        // Clear coinciding with another drop: set wins
        overflow_clr = 1'b1;
        push_byte(8'hAB);
        overflow_clr = 1'b0;
        n_total++; if (overflow !== 1'b1) $display("FAIL clr_race got %b expected 1", overflow); else n_pass++;
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        n_total++; if (overflow !== 1'b0) $display("FAIL clr got %b expected 0", overflow); else n_pass++;
        // Hold: head stays stable without out_ready
        tick();
        n_total++; if (out_data !== 8'h00) $display("FAIL hold got %h expected 00", out_data); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_total++; if (out_valid !== 1'b1 || out_data !== 8'(i))
                $display("FAIL drain[%0d] got %b/%h expected 1/%h", i, out_valid, out_data, 8'(i)); else n_pass++;
            pop_byte();
        end
        n_total++; if (empty !== 1'b1 || out_valid !== 1'b0 || line_cnt !== 5'd0)
            $display("FAIL drain_end got %b/%b/%0d expected 1/0/0", empty, out_valid, line_cnt); else n_pass++;
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
        in_data   = 8'h55;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_total++; if (count !== 5'd16 || overflow !== 1'b0)
            $display("FAIL full_pp got %0d/%b expected 16/0", count, overflow); else n_pass++;
        for (int i = 1; i < 16; i++) begin
            n_total++; if (out_data !== 8'h20 + 8'(i))
                $display("FAIL full_pp_drain[%0d] got %h expected %h", i, out_data, 8'h20 + 8'(i)); else n_pass++;
            pop_byte();
        end
        n_total++; if (out_valid !== 1'b1 || out_data !== 8'h55)
            $display("FAIL full_pp_last got %b/%h expected 1/55", out_valid, out_data); else n_pass++;
        pop_byte();
        n_total++; if (empty !== 1'b1) $display("FAIL full_pp_empty got %b expected 1", empty); else n_pass++;
    endtask

    task automatic test_lines();
        push_byte(8'h31);
        push_byte(8'h0A);
        push_byte(8'h32);
        push_byte(8'h0A);
        n_total++; if (line_cnt !== 5'd2 || line_avail !== 1'b1)
            $display("FAIL lines_4 got %0d/%b expected 2/1", line_cnt, line_avail); else n_pass++;
        pop_byte();
        pop_byte();
        n_total++; if (line_cnt !== 5'd1 || line_avail !== 1'b1)
            $display("FAIL lines_2 got %0d/%b expected 1/1", line_cnt, line_avail); else n_pass++;
        pop_byte();
        pop_byte();
        n_total++; if (line_cnt !== 5'd0 || line_avail !== 1'b0)
            $display("FAIL lines_0 got %0d/%b expected 0/0", line_cnt, line_avail); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        int         pushes = 0;
        int         cyc = 0;
        logic       iv;
        logic       rdy;
        logic       pop;
        logic [7:0] d;
        while (!(pushes == 40 && q.size() == 0) && cyc < 400) begin
            iv  = (pushes < 40) && ($urandom_range(0, 2) != 0);
            rdy = (pushes == 40) || ($urandom_range(0, 1) == 1);
            n_total++; if (out_valid !== (q.size() != 0) || count !== 5'(q.size()))
                $display("FAIL b2b_state[%0d] got %b/%0d expected %b/%0d", cyc, out_valid, count, q.size() != 0, q.size());
            else n_pass++;
            if (q.size() != 0) begin
                n_total++; if (out_data !== q[0])
                    $display("FAIL b2b_data[%0d] got %h expected %h", cyc, out_data, q[0]); else n_pass++;
            end
            pop = (q.size() != 0) && rdy;
            d   = 8'(pushes * 7 + 3);
            in_data   = d;
            in_valid  = iv;
            out_ready = rdy;
            tick();
            if (pop) void'(q.pop_front());
            if (iv && (q.size() < 16 || pop)) begin
                q.push_back(d);
                pushes++;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_total++; if (cyc >= 400) $display("FAIL b2b_timeout got %0d cycles expected under 400", cyc); else n_pass++;
    endtask

    task automatic test_reset_midway();
        push_byte(8'h11);
        push_byte(8'h0A);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        n_total++; if (count !== 5'd5 || line_cnt !== 5'd1)
            $display("FAIL mid_pre got %0d/%0d expected 5/1", count, line_cnt); else n_pass++;
        rstn     = 1'b1;
        in_data  = 8'h0A;
        in_valid = 1'b1;
        tick();
        rstn     = 1'b0;
        in_valid = 1'b0;
        n_total++; if (count !== 5'd0 || out_valid !== 1'b0 || line_cnt !== 5'd0 || overflow !== 1'b0)
            $display("FAIL mid_reset got %0d/%b/%0d/%b expected 0/0/0/0", count, out_valid, line_cnt, overflow);
        else n_pass++;
        tick();
        n_total++; if (count !== 5'd0 || empty !== 1'b1)
            $display("FAIL mid_lost got %0d/%b expected 0/1", count, empty); else n_pass++;
    endtask

    initial begin
        #2;
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_lines();
        test_back_to_back();
        test_reset_midway();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Byte buffer directly downstream of the UART receiver. It captures each received byte on the receiver's one-cycle ready pulse.
- Stores bytes in a first-word-fall-through FIFO and presents them to the consumer over a valid/ready interface.
- Tracks overflow and counts buffered line-terminator bytes, so command logic can wait for a complete line before draining.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of 2, minimum 2.
- AW, 4, pointer width; must equal log2(DEPTH).
- TERM, 8'h0A, byte value counted as a line terminator.

Ports:
- clk  input  1  system clock, same clock as the receiver.
- rstn  input  1  synchronous reset, active-high (rstn=1 resets on the next clk edge).
- in_data  input  8  received byte from the receiver's Data output.
- in_valid  input  1  one-cycle pulse from the receiver's Ready; in_data is valid in this cycle.
- out_data  output  8  head-of-FIFO byte; meaningful only while out_valid=1.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head byte in this cycle.
- count  output  AW+1  number of bytes stored, 0..DEPTH.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- overflow  output  1  sticky flag: at least one byte was dropped.
- overflow_clr  input  1  clears overflow.
- line_cnt  output  AW+1  number of stored bytes equal to TERM.
- line_avail  output  1  line_cnt!=0.

Behaviour:
- Reset values (synchronous, rstn=1):
  - wr_ptr=0, rd_ptr=0, count=0, line_cnt=0.
  - overflow=0, out_valid=0, empty=1, full=0, line_avail=0, out_data=8'h00.
  - Storage contents are don't-care.
  - Reset mid-operation discards all stored bytes.
  - An in_valid pulse coinciding with reset is lost.
- Push: in_valid=1 and (full=0 or pop in the same cycle).
  - Writes in_data at wr_ptr.
  - wr_ptr increments modulo DEPTH.
- Pop: out_valid=1 and out_ready=1.
  - Head entry is consumed.
  - rd_ptr increments modulo DEPTH.
  - out_ready while out_valid=0 is ignored.
- Latency: a byte pushed into an empty FIFO at edge N gives out_valid=1 and out_data=that byte after edge N (visible in cycle N+1). There is no bypass in the same cycle.
- out_data/out_valid are registered (first-word fall-through):
  - After a pop, the next entry appears in the following cycle with no bubble when count>=2.
  - out_data holds stable while out_valid=1 and out_ready=0.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- Full with in_valid=1 and pop in the same cycle: both accepted; count stays DEPTH; no overflow.
- Full with in_valid=1 and no pop: byte dropped, pointers unchanged, overflow<=1.
- Empty with out_ready=1: no effect; count never underflows.
- overflow is sticky until overflow_clr=1. If a drop and overflow_clr occur in the same cycle, the set wins (overflow=1).
- line_cnt update:
  - +1 on an accepted push with in_data==TERM.
  - -1 on a pop with out_data==TERM.
  - Both in the same cycle: unchanged.
  - Dropped bytes never count.
- Pointer wrap: wr_ptr and rd_ptr wrap from DEPTH-1 to 0. full/empty derive from count, not pointer equality.
- in_valid is a single-cycle pulse; consecutive pulses are at least one UART frame apart. The block must nevertheless accept a push every cycle.
- Byte order: out_data order equals in_valid order; bytes are not modified.

Test Plan:
- Reset, then push 8'h41 (single pulse) -> next cycle out_valid=1, out_data=8'h41, count=1, empty=0. Pop -> count=0, empty=1, out_valid=0.
- Push 16 bytes 8'h00..8'h0F with out_ready=0 -> full=1, count=16. Push 8'hAA -> dropped, overflow=1, count=16. Drain -> 8'h00..8'h0F in order, no 8'hAA.
- Full FIFO, push 8'h55 with out_ready=1 in the same cycle -> count stays 16, overflow stays 0, 8'h55 emerges last after draining.
- Push 8'h31, 8'h0A, 8'h32, 8'h0A -> line_cnt=2, line_avail=1. Pop two bytes -> line_cnt=1. Pop the remaining two -> line_cnt=0, line_avail=0.
- Set overflow, then assert overflow_clr in the same cycle as a new drop -> overflow=1. overflow_clr alone next cycle -> overflow=0.
- 40 interleaved push/pop with random out_ready across pointer wrap -> output sequence equals input sequence. Assert rstn=1 with count=5 -> next cycle count=0, out_valid=0, line_cnt=0, overflow=0.
